lsu_mem_ctrl: RTL and testbench
===============================

// Module: lsu_mem_ctrl
// PURPOSE
// - Load/store initiator for the byte-addressed data memory (11-bit addr, 32-bit aligned q, 4-bit byte-enable wren).
// - Accepts one RV32I load/store per handshake from the core.
// - Drives aligned word accesses; a misaligned access spanning two words is split into two beats.
// - Returns sign/zero-extended load data, or an error flag.
// PARAMETERS
// - ADDR_W  11  memory byte-address width (2 KiB); legal addresses 0 .. 2**ADDR_W-1
// PORTS
// - i_clk          in   1       clock, single domain
// - i_reset        in   1       synchronous, active-high reset
// - i_req_valid    in   1       request valid
// - o_req_ready    out  1       request accepted when valid&&ready
// - i_req_we       in   1       1=store, 0=load
// - i_req_funct3   in   3       LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010
// - i_req_addr     in   32      byte address
// - i_req_wdata    in   32      store data, right-justified
// - o_rsp_valid    out  1       one-cycle response pulse; no backpressure
// - o_rsp_rdata    out  32      extended load data; 0 for stores and errors
// - o_rsp_err      out  1       address out of range or illegal funct3; qualified by o_rsp_valid
// - o_mem_addr     out  ADDR_W  word-aligned address, bits[1:0]=00
// - o_mem_wdata    out  32      lane-positioned write data
// - o_mem_wren     out  4       byte enables; bit n = byte addr+n
// - i_mem_q        in   32      combinational read data for o_mem_addr
// BEHAVIOUR
// - Reset values, and while i_reset=1: state IDLE, o_req_ready=0, o_rsp_valid=0, o_rsp_err=0, o_rsp_rdata=0,
//   o_mem_addr=0, o_mem_wren=0.
// - o_mem_wren is gated combinationally by i_reset, so a reset mid-store writes nothing that cycle.
// - FSM IDLE -> BEAT0 -> [BEAT1] -> RESP -> IDLE.
//   - IDLE: o_req_ready=1. On accept, register we/funct3/addr/wdata and move to BEAT0.
//   - BEAT0: o_mem_addr={addr[ADDR_W-1:2],2'b00}; o_mem_wren=mask[3:0] if store, else 0; capture i_mem_q as q0.
//     Go to BEAT1 if mask[7:4]!=0, else RESP.
//   - BEAT1: o_mem_addr = BEAT0 address + 4; wren=mask[7:4] if store; capture q1. Go to RESP.
//   - RESP: o_rsp_valid=1 for exactly one cycle. Next state IDLE; o_req_ready returns to 1 the cycle after.
// - Size: sz = 1/2/4 bytes from funct3[1:0]; off = addr[1:0].
// - Lane mapping:
//   - mask = ({4'b0, szmask} << off), 8 bits.
//   - wsh = ({32'b0, wdata} << 8*off), 64 bits; beat0 drives wsh[31:0], beat1 drives wsh[63:32].
// - Load assembly:
//   - raw = ({q1, q0} >> 8*off)[31:0]; q1=0 when single-beat.
//   - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes raw.
// - Latency from accept edge: aligned / in-word = 3 cycles to o_rsp_valid (BEAT0, RESP); word-crossing = 4 cycles.
// - Errors, each detected at accept and skipping BEAT0/BEAT1 (no memory traffic, wren stays 0; response in 2 cycles,
//   rdata=0, err=1):
//   - addr[31:ADDR_W]!=0
//   - last byte addr+sz-1 > 2**ADDR_W-1 (no wrap to 0)
//   - illegal funct3: 011/110/111; store with funct3[2]=1
// - Back-to-back: a new request is only accepted in IDLE; at most one outstanding.
// - i_req_* are sampled only on accept and may change afterwards.
// STRUCTURE
// - Package lsu_pkg:
//   - funct3 localparams/enum (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   - state enum lsu_state_e {IDLE, BEAT0, BEAT1, RESP}
// - Sub-module lsu_lane_align (purely combinational): {funct3, off, wdata} -> {mask[7:0], wsh[63:0]};
//   {funct3, off, q1, q0} -> extended rdata.
// - Top holds the FSM, request registers and q0/q1 capture registers.
// TESTING (bench pairs with the data-memory model, reset 1 cycle high first)
// - SW 0x100 data 0xDEADBEEF, then LW 0x100:
//   - store: wren=1111, 3-cycle latency
//   - load: rdata=0xDEADBEEF, err=0
// - SB 0x103 data 0x80, then LB 0x103 -> rdata 0xFFFFFF80; LBU 0x103 -> 0x00000080; store drove wren=1000, wdata[31:24]=0x80.
// - SW 0x0FE data 0x11223344: two beats, addr 0x0FC wren=1100 then 0x100 wren=0011.
//   LW 0x0FE -> 0x11223344 with 4-cycle latency; LH 0x0FF -> 0x00002233.
// - LW 0x7FE and SB 0x800 -> err=1, rdata=0, no wren pulses. funct3=011 load -> err=1.
// - Assert i_reset during BEAT1 of a crossing SW:
//   - o_mem_wren=0 that cycle
//   - post-reset state IDLE, ready=1 the cycle after i_reset falls
//   - only beat0 bytes changed in memory
// - Hold i_req_valid high for 3 aligned LWs: exactly 3 rsp pulses, each accept separated by 3 cycles.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg
// Shared definitions for the load/store unit memory controller:
//   - RV32I load/store funct3 encodings
//   - controller state encoding
//   - helpers mapping funct3[1:0] to access size
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    // Byte-lane mask of an access starting at lane 0.
    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

    // Access size in bytes minus one (offset of the last byte).
    function automatic logic [1:0] size_m1(input logic [1:0] sz);
        case (sz)
            2'b00:   size_m1 = 2'd0;
            2'b01:   size_m1 = 2'd1;
            default: size_m1 = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align
// Purely combinational byte-lane steering for one access.
// Ports:
//   funct3_i  access type (size in [1:0], unsigned flag in [2])
//   off_i     byte offset inside the first word
//   wdata_i   right-justified store data
//   q0_i      first-beat read word
//   q1_i      low 3 bytes of second-beat read word (0 when single beat)
//   mask_o    8-bit byte enables across the two beats
//   wsh_o     lane-positioned store data, [31:0] beat0, [63:32] beat1
//   rdata_o   extended load data
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] q0_i,
    input  logic [23:0] q1_i,
    output logic [7:0]  mask_o,
    output logic [63:0] wsh_o,
    output logic [31:0] rdata_o
);

    logic [31:0] raw;

    assign mask_o = {4'b0000, size_mask(funct3_i[1:0])} << off_i;
    assign wsh_o  = {32'b0, wdata_i} << {off_i, 3'b000};

    // A 4-byte window starting at offset 1..3 never reaches the top byte
    // of the second word, so only its low 3 bytes are carried.
    always_comb begin
        case (off_i)
            2'd0:    raw = q0_i;
            2'd1:    raw = {q1_i[7:0],  q0_i[31:8]};
            2'd2:    raw = {q1_i[15:0], q0_i[31:16]};
            default: raw = {q1_i[23:0], q0_i[31:24]};
        endcase
    end

    always_comb begin
        case (funct3_i)
            F3_B:    rdata_o = {{24{raw[7]}}, raw[7:0]};
            F3_H:    rdata_o = {{16{raw[15]}}, raw[15:0]};
            F3_BU:   rdata_o = {24'b0, raw[7:0]};
            F3_HU:   rdata_o = {16'b0, raw[15:0]};
            default: rdata_o = raw;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl
// Load/store initiator for a byte-addressed data memory with aligned
// 32-bit words. One request outstanding; misaligned word-crossing
// accesses are split into two beats.
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_req_*/o_req_ready     request handshake (we, funct3, addr, wdata)
//   o_rsp_valid/rdata/err   one-cycle response pulse
//   o_mem_addr/wdata/wren   word-aligned memory access, byte enables
//   i_mem_q                 combinational read data for o_mem_addr
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [2:0]        i_req_funct3,
    input  logic [31:0]       i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_rsp_valid,
    output logic [31:0]       o_rsp_rdata,
    output logic              o_rsp_err,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [3:0]        o_mem_wren,
    input  logic [31:0]       i_mem_q
);

    lsu_state_e        state_q, state_d;
    logic              we_q, err_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, q0_q;
    logic [23:0]       q1_q;

    logic              accept, req_err, f3_bad;
    logic [ADDR_W:0]   last_byte;
    logic [ADDR_W-1:0] word0, word1;
    logic [7:0]        mask;
    logic [63:0]       wsh;
    logic [31:0]       ld_data;

    assign accept = i_req_valid && o_req_ready;

    // Range check is done one bit wider so an access running past the
    // top of memory shows up as a carry instead of wrapping to 0.
    assign last_byte = {1'b0, i_req_addr[ADDR_W-1:0]}
                     + {{(ADDR_W-1){1'b0}}, size_m1(i_req_funct3[1:0])};
    assign f3_bad    = (i_req_funct3 == 3'b011) || (i_req_funct3 == 3'b110)
                    || (i_req_funct3 == 3'b111) || (i_req_we && i_req_funct3[2]);
    assign req_err   = (|i_req_addr[31:ADDR_W]) || last_byte[ADDR_W] || f3_bad;

    assign word0 = {addr_q[ADDR_W-1:2], 2'b00};
    assign word1 = word0 + ADDR_W'(4);

    lsu_lane_align u_align (
        .funct3_i (f3_q),
        .off_i    (addr_q[1:0]),
        .wdata_i  (wdata_q),
        .q0_i     (q0_q),
        .q1_i     (q1_q),
        .mask_o   (mask),
        .wsh_o    (wsh),
        .rdata_o  (ld_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = req_err ? RESP : BEAT0;
            BEAT0:   state_d = (|mask[7:4]) ? BEAT1 : RESP;
            BEAT1:   state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            q0_q    <= '0;
            q1_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= i_req_we;
                err_q   <= req_err;
                f3_q    <= i_req_funct3;
                addr_q  <= i_req_addr[ADDR_W-1:0];
                wdata_q <= i_req_wdata;
                q1_q    <= '0;
            end
            if (state_q == BEAT0) q0_q <= i_mem_q;
            if (state_q == BEAT1) q1_q <= i_mem_q[23:0];
        end
    end

    // Outputs are decoded from state and forced quiet while reset is
    // asserted, so a reset landing mid-store writes nothing that cycle.
    always_comb begin
        o_req_ready = 1'b0;
        o_rsp_valid = 1'b0;
        o_rsp_err   = 1'b0;
        o_rsp_rdata = '0;
        o_mem_addr  = '0;
        o_mem_wdata = wsh[31:0];
        o_mem_wren  = 4'b0000;
        if (!i_reset) begin
            case (state_q)
                IDLE:  o_req_ready = 1'b1;
                BEAT0: begin
                    o_mem_addr = word0;
                    if (we_q) o_mem_wren = mask[3:0];
                end
                BEAT1: begin
                    o_mem_addr  = word1;
                    o_mem_wdata = wsh[63:32];
                    if (we_q) o_mem_wren = mask[7:4];
                end
                default: begin
                    o_rsp_valid = 1'b1;
                    o_rsp_err   = err_q;
                    if (!err_q && !we_q) o_rsp_rdata = ld_data;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_we = 1'b0;
    logic [2:0]  i_req_funct3 = 3'b000;
    logic [31:0] i_req_addr = '0;
    logic [31:0] i_req_wdata = '0;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic [10:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wren;
    logic [31:0] i_mem_q;

    int checks = 0;
    int failures = 0;

    logic [7:0] dmem    [0:2047];
    logic [7:0] ref_mem [0:2047];

    int          last_lat, last_nwr;
    logic [31:0] last_rdata;
    logic        last_err;
    logic [3:0]  last_wren  [2];
    logic [10:0] last_addr  [2];
    logic [31:0] last_wdata [2];

    always #5 i_clk = ~i_clk;

    lsu_mem_ctrl #(.ADDR_W(11)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_we     (i_req_we),
        .i_req_funct3 (i_req_funct3),
        .i_req_addr   (i_req_addr),
        .i_req_wdata  (i_req_wdata),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_rdata  (o_rsp_rdata),
        .o_rsp_err    (o_rsp_err),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_wren   (o_mem_wren),
        .i_mem_q      (i_mem_q)
    );

    // Data memory attached to the DUT: combinational read, byte-enabled write.
    logic [10:0] wa;
    assign wa      = {o_mem_addr[10:2], 2'b00};
    assign i_mem_q = {dmem[wa + 11'd3], dmem[wa + 11'd2], dmem[wa + 11'd1], dmem[wa]};

    initial begin
        for (int i = 0; i < 2048; i++) dmem[i] = 8'($urandom);
        forever begin
            @(posedge i_clk);
            for (int n = 0; n < 4; n++)
                if (o_mem_wren[n]) dmem[int'(wa) + n] = o_mem_wdata[8*n +: 8];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int mem_diff();
        int d = 0;
        for (int i = 0; i < 2048; i++) if (dmem[i] !== ref_mem[i]) d++;
        return d;
    endfunction

    // Reference load: gather bytes little-endian, then extend by type.
    function automatic logic [31:0] ld_model(input logic [2:0] f3, input int a);
        logic [31:0] v = '0;
        int sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[a + i];
        case (f3)
            3'b000:  v = {{24{v[7]}}, v[7:0]};
            3'b001:  v = {{16{v[15]}}, v[15:0]};
            default: ;
        endcase
        return v;
    endfunction

    // Issue one request (called just after a falling edge with DUT idle),
    // observe until the response, compare against the model.
    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
        int sz, nb, lat_e, w0, b, bt, cyc;
        logic e, got;
        logic [3:0]  ew [2];
        logic [31:0] ed [2];
        logic [31:0] er, lanes;

        sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        e  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2])
           || (addr > 32'd2047) || (longint'(addr) + sz > 2048);
        ew[0] = '0; ew[1] = '0; ed[0] = '0; ed[1] = '0; er = '0; nb = 0;
        lat_e = e ? 2 : ((int'(addr % 4) + sz > 4) ? 4 : 3);
        if (!e) begin
            w0 = int'(addr >> 2);
            for (int i = 0; i < sz; i++) begin
                b  = int'(addr) + i;
                bt = (b >> 2) - w0;
                ew[bt][b % 4] = 1'b1;
                ed[bt][8*(b % 4) +: 8] = wd[8*i +: 8];
            end
            nb = we ? ((ew[1] != 0) ? 2 : 1) : 0;
            if (!we) er = ld_model(f3, int'(addr));
        end

        i_req_valid = 1'b1; i_req_we = we; i_req_funct3 = f3;
        i_req_addr = addr; i_req_wdata = wd;
        for (int k = 0; k < 20; k++) begin
            if (o_req_ready) break;
            @(negedge i_clk);
        end
        chk("accept_ready", o_req_ready, 1);
        @(negedge i_clk);
        i_req_valid = 1'b0; i_req_we = 1'($urandom); i_req_funct3 = 3'($urandom);
        i_req_addr = $urandom; i_req_wdata = $urandom;

        got = 1'b0; last_nwr = 0; last_lat = 0; last_rdata = 'x; last_err = 1'bx;
        last_wren[0] = '0; last_wren[1] = '0;
        for (cyc = 2; cyc < 12; cyc++) begin
            if (o_mem_wren != 4'b0000) begin
                if (last_nwr < 2) begin
                    last_wren[last_nwr]  = o_mem_wren;
                    last_addr[last_nwr]  = o_mem_addr;
                    last_wdata[last_nwr] = o_mem_wdata;
                end
                last_nwr++;
            end
            if (o_rsp_valid) begin
                got = 1'b1; last_lat = cyc; last_rdata = o_rsp_rdata; last_err = o_rsp_err;
                break;
            end
            @(negedge i_clk);
        end
        chk("rsp_seen", got, 1);
        chk("latency", last_lat, lat_e);
        chk("rsp_err", last_err, e);
        chk("rsp_rdata", last_rdata, er);
        chk("wren_pulses", last_nwr, nb);
        for (int k = 0; k < nb && k < last_nwr && k < 2; k++) begin
            for (int n = 0; n < 4; n++) lanes[8*n +: 8] = {8{ew[k][n]}};
            chk("beat_wren", last_wren[k], ew[k]);
            chk("beat_addr", last_addr[k], 11'(((addr & ~32'd3) + 32'(4*k))));
            chk("beat_wdata", last_wdata[k] & lanes, ed[k]);
        end
        @(negedge i_clk);
        chk("rsp_one_pulse", o_rsp_valid, 0);
        chk("ready_after_rsp", o_req_ready, 1);
        if (we && !e)
            for (int i = 0; i < sz; i++) ref_mem[int'(addr) + i] = wd[8*i +: 8];
        chk("mem_contents", mem_diff(), 0);
    endtask

    initial begin
        int nacc, nrsp;
        int acc_cyc [3];
        logic [31:0] a;
        logic [2:0]  f;
        logic [2:0]  legal [5];
        legal[0] = 3'b000; legal[1] = 3'b001; legal[2] = 3'b010;
        legal[3] = 3'b100; legal[4] = 3'b101;

        // Reset for one cycle; outputs quiet while it is high.
        @(negedge i_clk);
        for (int i = 0; i < 2048; i++) ref_mem[i] = dmem[i];
        chk("rst_ready", o_req_ready, 0);
        chk("rst_rsp_valid", o_rsp_valid, 0);
        chk("rst_rsp_err", o_rsp_err, 0);
        chk("rst_rdata", o_rsp_rdata, 0);
        chk("rst_mem_addr", o_mem_addr, 0);
        chk("rst_wren", o_mem_wren, 0);
        i_reset = 1'b0;
        #1;
        chk("post_rst_ready", o_req_ready, 1);

        // Aligned word store/load.
        txn(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
        chk("sw_wren", last_wren[0], 4'b1111);
        chk("sw_lat", last_lat, 3);
        txn(1'b0, 3'b010, 32'h100, 32'h0);
        chk("lw_data", last_rdata, 32'hDEADBEEF);
        chk("lw_err", last_err, 0);

        // Byte store to the top lane, signed and unsigned reload.
        txn(1'b1, 3'b000, 32'h103, 32'hABCDEF80);
        chk("sb_wren", last_wren[0], 4'b1000);
        chk("sb_lane", last_wdata[0][31:24], 8'h80);
        txn(1'b0, 3'b000, 32'h103, 32'h0);
        chk("lb_data", last_rdata, 32'hFFFFFF80);
        txn(1'b0, 3'b100, 32'h103, 32'h0);
        chk("lbu_data", last_rdata, 32'h00000080);

        // Word-crossing store and loads.
        txn(1'b1, 3'b010, 32'h0FE, 32'h11223344);
        chk("sw_x_beats", last_nwr, 2);
        chk("sw_x_addr0", last_addr[0], 11'h0FC);
        chk("sw_x_wren0", last_wren[0], 4'b1100);
        chk("sw_x_addr1", last_addr[1], 11'h100);
        chk("sw_x_wren1", last_wren[1], 4'b0011);
        txn(1'b0, 3'b010, 32'h0FE, 32'h0);
        chk("lw_x_data", last_rdata, 32'h11223344);
        chk("lw_x_lat", last_lat, 4);
        txn(1'b0, 3'b001, 32'h0FF, 32'h0);
        chk("lh_x_data", last_rdata, 32'h00002233);

        // Error cases.
        txn(1'b0, 3'b010, 32'h7FE, 32'h0);
        chk("lw_top_err", last_err, 1);
        txn(1'b1, 3'b000, 32'h800, 32'h55);
        chk("sb_oor_err", last_err, 1);
        chk("sb_oor_nowr", last_nwr, 0);
        txn(1'b0, 3'b011, 32'h10, 32'h0);
        chk("f3_011_err", last_err, 1);

        // Reset asserted during the second beat of a crossing store.
        i_req_valid = 1'b1; i_req_we = 1'b1; i_req_funct3 = 3'b010;
        i_req_addr = 32'h1FE; i_req_wdata = 32'hA1B2C3D4;
        chk("mr_ready", o_req_ready, 1);
        @(negedge i_clk);
        i_req_valid = 1'b0;
        chk("mr_beat0_wren", o_mem_wren, 4'b1100);
        chk("mr_beat0_addr", o_mem_addr, 11'h1FC);
        @(negedge i_clk);
        chk("mr_beat1_wren", o_mem_wren, 4'b0011);
        i_reset = 1'b1;
        #1;
        chk("mr_wren_gated", o_mem_wren, 0);
        chk("mr_ready_low", o_req_ready, 0);
        chk("mr_addr_zero", o_mem_addr, 0);
        @(negedge i_clk);
        i_reset = 1'b0;
        #1;
        chk("mr_ready_after", o_req_ready, 1);
        chk("mr_rsp_quiet", o_rsp_valid, 0);
        ref_mem[12'h1FE] = 8'hD4;
        ref_mem[12'h1FF] = 8'hC3;
        chk("mr_mem", mem_diff(), 0);
        txn(1'b0, 3'b010, 32'h1FE, 32'h0);

        // Valid held high across three aligned loads.
        i_req_valid = 1'b1; i_req_we = 1'b0; i_req_funct3 = 3'b010; i_req_addr = 32'h100;
        nacc = 0; nrsp = 0;
        for (int c = 0; c < 20; c++) begin
            if (o_rsp_valid) begin
                nrsp++;
                chk("b2b_rdata", o_rsp_rdata, ld_model(3'b010, 32'h100));
            end
            if (i_req_valid && o_req_ready && nacc < 3) begin
                acc_cyc[nacc] = c;
                nacc++;
            end else if (nacc == 3) begin
                i_req_valid = 1'b0;
            end
            @(negedge i_clk);
        end
        i_req_valid = 1'b0;
        chk("b2b_accepts", nacc, 3);
        chk("b2b_rsps", nrsp, 3);
        chk("b2b_gap1", acc_cyc[1] - acc_cyc[0], 3);
        chk("b2b_gap2", acc_cyc[2] - acc_cyc[1], 3);

        // Randomized traffic, biased toward the top of memory.
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 15))
                0:       a = $urandom;
                1, 2:    a = $urandom_range(2040, 2055);
                default: a = $urandom_range(0, 2047);
            endcase
            f = ($urandom_range(0, 4) == 0) ? 3'($urandom) : legal[$urandom_range(0, 4)];
            txn(1'($urandom), f, a, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
